// File: rtl/vga_timing_multi_if.sv
// Bundle between the VGA timing generator and its consumer.
// master: generator side (takes en/mode, drives timing); slave: consumer.
interface vga_timing_multi_if #(
  parameter int HW = 11,
  parameter int VW = 10
);
  logic          en_i;
  logic [1:0]    mode_i;
  logic [1:0]    mode_o;
  logic          pix_stb_o;
  logic [HW-1:0] x_o;
  logic [VW-1:0] y_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;
  logic          line_start_o;
  logic          frame_start_o;

  modport master (
    input  en_i, mode_i,
    output mode_o, pix_stb_o, x_o, y_o,
    output de_o, hs_o, vs_o,
    output line_start_o, frame_start_o
  );

  modport slave (
    output en_i, mode_i,
    input  mode_o, pix_stb_o, x_o, y_o,
    input  de_o, hs_o, vs_o,
    input  line_start_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_multi.sv
// Multi-mode VGA timing generator: pixel-strobe divider, x/y counters,
// frame-boundary mode switch, and a strobe-clocked sync/blank delay line.
// Ports: clk_i, rst_i (sync, active-high), bus (vga_timing_multi_if.master).
module vga_timing_multi #(
  parameter int DIVISOR  = 4,
  parameter int PIPE_DLY = 2,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  vga_timing_multi_if.master  bus
);
  localparam int DW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int NST = (PIPE_DLY == 0) ? 1 : PIPE_DLY;
  localparam logic [DW-1:0] DLAST = DW'(DIVISOR - 1);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic [1:0]    mode_q, mode_d;
  logic          ls_q, fs_q;
  // tap bits: {hs, vs, de}
  logic [NST-1:0][2:0] tap_q;

  logic [HW-1:0] hd, hss, hse, htm1;
  logic [VW-1:0] vd, vss, vse, vtm1;
  logic          pol;
  logic          stb, x_wrap, y_wrap, eof;
  logic          de_raw, hs_raw, vs_raw;
  logic          pol_in;

  always_comb begin
    hd = '0; hss = '0; hse = '0; htm1 = '0;
    vd = '0; vss = '0; vse = '0; vtm1 = '0;
    pol = 1'b0;
    unique case (mode_q)
      2'd0: begin
        hd = HW'(640);  hss = HW'(656);
        hse = HW'(752); htm1 = HW'(799);
        vd = VW'(480);  vss = VW'(490);
        vse = VW'(492); vtm1 = VW'(524);
        pol = 1'b0;
      end
      2'd1: begin
        hd = HW'(800);  hss = HW'(840);
        hse = HW'(968); htm1 = HW'(1055);
        vd = VW'(600);  vss = VW'(601);
        vse = VW'(605); vtm1 = VW'(627);
        pol = 1'b1;
      end
      2'd2: begin
        hd = HW'(1024);  hss = HW'(1048);
        hse = HW'(1184); htm1 = HW'(1343);
        vd = VW'(768);   vss = VW'(771);
        vse = VW'(777);  vtm1 = VW'(805);
        pol = 1'b0;
      end
      2'd3: begin
        hd = HW'(1366);  hss = HW'(1436);
        hse = HW'(1579); htm1 = HW'(1791);
        vd = VW'(768);   vss = VW'(771);
        vse = VW'(774);  vtm1 = VW'(797);
        pol = 1'b1;
      end
    endcase
  end

  // Modes 1 and 3 use positive sync; reset takes polarity from mode_i.
  assign pol_in = (bus.mode_i == 2'd1) || (bus.mode_i == 2'd3);

  assign stb    = bus.en_i && (div_q == DLAST);
  assign x_wrap = (x_q == htm1);
  assign y_wrap = (y_q == vtm1);
  assign eof    = x_wrap && y_wrap;

  assign de_raw = (x_q < hd) && (y_q < vd);
  assign hs_raw = ((x_q >= hss) && (x_q < hse)) ? pol : ~pol;
  assign vs_raw = ((y_q >= vss) && (y_q < vse)) ? pol : ~pol;

  always_comb begin
    div_d  = div_q;
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    if (bus.en_i)
      div_d = stb ? '0 : div_q + 1'b1;
    if (stb) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap)
        y_d = y_wrap ? '0 : y_q + 1'b1;
      // mode_i is only looked at on the last strobe of a frame
      if (eof)
        mode_d = bus.mode_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= bus.mode_i;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      for (int i = 0; i < NST; i++)
        tap_q[i] <= {~pol_in, ~pol_in, 1'b0};
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      ls_q   <= stb && x_wrap;
      fs_q   <= stb && eof;
      // not flushed on mode change: old sync tails drain out
      if (stb) begin
        tap_q[0] <= {hs_raw, vs_raw, de_raw};
        for (int i = 1; i < NST; i++)
          tap_q[i] <= tap_q[i-1];
      end
    end
  end

  assign bus.mode_o        = mode_q;
  assign bus.pix_stb_o     = stb;
  assign bus.x_o           = x_q;
  assign bus.y_o           = y_q;
  assign bus.hs_o          = tap_q[NST-1][2];
  assign bus.vs_o          = tap_q[NST-1][1];
  assign bus.de_o          = tap_q[NST-1][0];
  assign bus.line_start_o  = ls_q;
  assign bus.frame_start_o = fs_q;
endmodule
